i2c_bus_arbiter: RTL and testbench

// - Shares the single HDMI-TX/camera I2C bus (I2C_SCL/I2C_SDA) between independent masters: adv7513_init, adv7513_reg_read, camera config.
// - Grants one master at a time by round-robin, muxes only the owner's open-drain drive onto the pads, and enforces an idle gap between transactions.
// - A watchdog revokes a grant held too long.
// - Sits between the I2C master FSMs and the top-level tri-state pads.

---
 rtl/i2c_arb_pkg.sv | 8 +
 rtl/i2c_bus_arbiter_rr_pick.sv | 24 ++
 rtl/i2c_bus_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding and master indices for the I2C bus arbiter
package i2c_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWNED = 2'd1, GAP = 2'd2} arb_state_e;
  localparam int N_REQ_DEFAULT = 3;
  localparam int ARB_ADV_INIT = 0;
  localparam int ARB_ADV_READ = 1;
  localparam int ARB_CAM_CFG  = 2;
endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request searching upward from ptr+1
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx,
  output logic          valid
);
  // scan farthest-first so the nearest requester after ptr is the last writer
  always_comb begin
    pick_idx = '0;
    valid = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[IW'((int'(ptr) + i) % N)]) begin
        pick_idx = IW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end
  assign pick_oh = valid ? N'(1) << pick_idx : '0;
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner of the shared I2C bus with idle gap and hold watchdog
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int GAP_CYCLES = 600,
  parameter int TIMEOUT    = 5000000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  input  logic [N_REQ-1:0] scl_drv_low,
  input  logic [N_REQ-1:0] sda_drv_low,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             timeout_err,
  output logic [2:0]       timeout_id
);
  localparam int IW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be 2..8");
  end
  if (GAP_CYCLES < 1 || (64'(GAP_CYCLES) >> CNT_W) != 0 || (64'(TIMEOUT) >> CNT_W) != 0) begin : g_bad_cnt
    $error("GAP_CYCLES/TIMEOUT out of range for CNT_W");
  end
  arb_state_e state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, pick_oh;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d, terr_q, terr_d, pick_valid, done, expired;
  logic [2:0] tid_q, tid_d;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(req), .ptr(ptr_q), .pick_oh(pick_oh), .pick_idx(pick_idx), .valid(pick_valid)
  );
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign done = rel[owner_q] | ~req[owner_q];
  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    cnt_d = cnt_inc;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    terr_d = 1'b0;
    tid_d = tid_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = OWNED;
          gnt_d = pick_oh;
          owner_d = pick_idx;
          ptr_d = pick_idx;
        end
      end
      // a normal release wins over a coincident watchdog expiry
      OWNED: begin
        if (done || expired) begin
          state_d = GAP;
          gnt_d = '0;
          cnt_d = '0;
          terr_d = !done;
          tid_d = done ? tid_q : 3'(owner_q);
        end else begin
          scl_oe_d = scl_drv_low[owner_q];
          sda_oe_d = sda_drv_low[owner_q];
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= IW'(N_REQ - 1);
      cnt_q <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      terr_q <= 1'b0;
      tid_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      terr_q <= terr_d;
      tid_q <= tid_d;
    end
  end
  assign gnt = gnt_q;
  assign busy = state_q != IDLE;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign timeout_err = terr_q;
  assign timeout_id = tid_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed and random stimulus checked against a behavioural bus-ownership model
module tb_i2c_bus_arbiter;
  localparam int N = 3;
  localparam int GAP = 4;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0, rel = '0, scl_drv_low = '0, sda_drv_low = '0;
  logic [N-1:0] gnt;
  logic busy, scl_oe, sda_oe, timeout_err;
  logic [2:0] timeout_id;
  int errs = 0, checks = 0;
  int m_owner = -1, m_held = 0, m_gap = 0, m_last = N - 1;
  logic m_scl = 1'b0, m_sda = 1'b0, m_terr = 1'b0;
  logic [2:0] m_tid = '0;
  always #5 clk = ~clk;
  i2c_bus_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel), .scl_drv_low(scl_drv_low),
    .sda_drv_low(sda_drv_low), .gnt(gnt), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // ownership model: who holds the bus, how long, and how much idle gap remains
  task automatic model_step();
    if (reset) begin
      m_owner = -1; m_gap = 0; m_last = N - 1;
      m_scl = 0; m_sda = 0; m_terr = 0; m_tid = 0;
      return;
    end
    m_terr = 0; m_scl = 0; m_sda = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (rel[m_owner] || !req[m_owner] || m_held == TO) begin
        if (!rel[m_owner] && req[m_owner]) begin
          m_terr = 1;
          m_tid = 3'(m_owner);
        end
        m_owner = -1;
        m_gap = GAP;
      end else begin
        m_scl = scl_drv_low[m_owner];
        m_sda = sda_drv_low[m_owner];
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c; m_last = c; m_held = 0;
          break;
        end
      end
    end
  endtask
  task automatic cyc();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check("cyc", 32'({gnt, busy, scl_oe, sda_oe, timeout_err, timeout_id}),
          32'({eg, (m_owner >= 0 || m_gap > 0), m_scl, m_sda, m_terr, m_tid}));
  endtask
  task automatic wait_gnt();
    for (int n = 0; n < 20 && gnt == '0; n++) cyc();
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 300 && busy; n++) cyc();
  endtask
  initial begin
    int n;
    int rr_exp[5] = '{0, 1, 2, 0, 1};
    bit slow;
    cyc(); cyc();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_out", 32'({busy, scl_oe, sda_oe, timeout_err, timeout_id}), 0);
    reset = 0; req = 3'b001;
    cyc();
    check("gnt_lat", 32'(gnt), 32'b001);
    scl_drv_low = 3'b001;
    cyc();
    check("scl_on", 32'(scl_oe), 1);
    scl_drv_low = 3'b000;
    cyc();
    check("scl_off", 32'(scl_oe), 0);
    rel = 3'b001;
    cyc();
    rel = 0; req = 0;
    check("rel_gnt", 32'(gnt), 0);
    n = 0;
    while (busy && n < 20) begin n++; cyc(); end
    check("gap_len", 32'(n), GAP);
    reset = 1; cyc(); reset = 0;
    req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt();
      check("rr_order", 32'(gnt), 32'(1 << rr_exp[g]));
      rel = gnt;
      cyc();
      rel = 0;
    end
    req = 0; wait_idle();
    req = 3'b001; wait_gnt();
    rel = 3'b001; req = 0;
    cyc();
    rel = 0; req = 3'b010;
    for (int k = 0; k < GAP; k++) begin
      cyc();
      check("gap_hold", 32'(gnt), 0);
    end
    cyc();
    check("gap_gnt", 32'(gnt), 32'b010);
    rel = 3'b010; req = 0; cyc(); rel = 0; wait_idle();
    req = 3'b100; wait_gnt();
    check("to_owner", 32'(gnt), 32'b100);
    n = 0;
    while (gnt != '0 && n < 300) begin n++; cyc(); end
    check("to_len", 32'(n), TO);
    check("to_err", 32'(timeout_err), 1);
    check("to_id", 32'(timeout_id), 2);
    check("to_pads", 32'({scl_oe, sda_oe}), 0);
    cyc();
    check("to_pulse", 32'(timeout_err), 0);
    check("to_id_hold", 32'(timeout_id), 2);
    req = 0; wait_idle();
    req = 3'b001; wait_gnt();
    scl_drv_low = 3'b010; sda_drv_low = 3'b001;
    cyc();
    check("nonown_scl", 32'(scl_oe), 0);
    check("own_sda", 32'(sda_oe), 1);
    reset = 1;
    cyc();
    check("mid_rst", 32'({gnt, sda_oe, busy}), 0);
    reset = 0; scl_drv_low = 0; sda_drv_low = 0; req = 3'b110;
    wait_gnt();
    check("post_rst", 32'(gnt), 32'b010);
    for (int t = 0; t < 6000; t++) begin
      if (t % 1000 == 0) slow = !slow;
      reset = ($urandom_range(0, 999) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, slow ? 199 : 19) == 0) req[b] = ~req[b];
        rel[b] = !slow && ($urandom_range(0, 29) == 0);
      end
      scl_drv_low = N'($urandom);
      sda_drv_low = N'($urandom);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
